// File: rtl/dds_sample_feeder_if.sv
// ---------------------------------------------------------------------------
// dds_sample_feeder_if
// Waveform-ROM fetch handshake between the DDS sample feeder and the ROM.
//   RomReq   feeder -> ROM  fetch request, held until acknowledged
//   RomAddr  feeder -> ROM  fetch address, stable while RomReq is high
//   RomAck   ROM -> feeder  data valid (may assert in the first RomReq cycle)
//   RomData  ROM -> feeder  sample word, valid while RomAck is high
// ---------------------------------------------------------------------------
interface dds_sample_feeder_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12
);
    logic              RomReq;
    logic [ADDR_W-1:0] RomAddr;
    logic              RomAck;
    logic [DATA_W-1:0] RomData;

    // Feeder side
    modport master (
        output RomReq,
        output RomAddr,
        input  RomAck,
        input  RomData
    );

    // ROM side
    modport slave (
        input  RomReq,
        input  RomAddr,
        output RomAck,
        output RomData
    );
endinterface

// File: rtl/dds_sample_feeder.sv
// ---------------------------------------------------------------------------
// dds_sample_feeder
// Paces waveform-ROM fetches at the DDSMode rate, owns the 32-bit phase
// accumulator and keeps the two-deep sample history for the interpolator.
//   Fg_CLK       system clock, rising edge
//   Fg_RESETn    asynchronous active-low reset
//   DDSMode      rate select (1/10/100/1000/10000 clocks per sample)
//   TuningWord   phase increment, sampled at accepted ticks
//   RunEn        enables sample ticks
//   ClrUnderrun  synchronous clear of Underrun
//   rom          ROM request/acknowledge handshake (master side)
//   out_1/out_2  newest / previous sample, sample placed at bits [29:18]
//   DDSEnable    one-cycle pulse when a new history has been committed
//   Underrun     sticky flag, a tick arrived while a fetch was outstanding
// ---------------------------------------------------------------------------
module dds_sample_feeder #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12
) (
    input  logic                Fg_CLK,
    input  logic                Fg_RESETn,
    input  logic [2:0]          DDSMode,
    input  logic [31:0]         TuningWord,
    input  logic                RunEn,
    input  logic                ClrUnderrun,
    dds_sample_feeder_if.master rom,
    output logic [31:0]         out_1,
    output logic [31:0]         out_2,
    output logic                DDSEnable,
    output logic                Underrun
);
    localparam int CNT_W = 14;  // holds 9999

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              busy;

    logic [31:0]       phase;
    logic [31:0]       phase_next;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  period_last;
    logic [2:0]        mode_q;

    logic              mode_change;
    logic              tick;
    logic              ack;
    logic              accept;
    logic              drop;

    // Terminal count D-1 for the selected rate; unused codes run every clock.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        period_last = '0;
        case (DDSMode)
            3'd1:    period_last = CNT_W'(9);
            3'd2:    period_last = CNT_W'(99);
            3'd3:    period_last = CNT_W'(999);
            3'd4:    period_last = CNT_W'(9999);
            default: period_last = '0;
        endcase
    end

    // A mode change restarts the period and suppresses the tick on that edge.
    assign mode_change = (DDSMode != mode_q);
    assign tick        = RunEn && !mode_change && (cnt == period_last);
    assign ack         = busy && rom.RomAck;
    // A tick can ride on the commit edge, which keeps mode 0 back-to-back.
    assign accept      = tick && (!busy || ack);
    assign drop        = tick && busy && !ack;
    assign phase_next  = phase + TuningWord;

    // ---- control FSM: state register ----
    always_ff @(posedge Fg_CLK or negedge Fg_RESETn) begin
        if (!Fg_RESETn) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all
            // registers see pre-edge values regardless of process order.
            state <= state_next;
        end
    end

    // ---- control FSM: next state ----
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept)          state_next = FETCH;
            FETCH: if (ack && !accept)  state_next = IDLE;
        endcase
    end

    // ---- control FSM: outputs ----
    always_comb begin
        busy        = (state == FETCH);
        rom.RomReq  = busy;
        rom.RomAddr = addr_q;
    end

    // ---- datapath ----
    always_ff @(posedge Fg_CLK or negedge Fg_RESETn) begin
        if (!Fg_RESETn) begin
            phase     <= '0;
            addr_q    <= '0;
            cnt       <= '0;
            mode_q    <= '0;
            out_1     <= '0;
            out_2     <= '0;
            DDSEnable <= 1'b0;
            Underrun  <= 1'b0;
        end else begin
            mode_q <= DDSMode;

            if (!RunEn || mode_change || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (accept) begin
                phase  <= phase_next;
                addr_q <= phase_next[31 -: ADDR_W];
            end

            DDSEnable <= ack;
            if (ack) begin
                out_2 <= out_1;
                out_1 <= {2'b00, rom.RomData, {(30 - DATA_W){1'b0}}};
            end

            // A drop on the same edge as a clear keeps the flag set.
            if (drop) begin
                Underrun <= 1'b1;
            end else if (ClrUnderrun) begin
                Underrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dds_sample_feeder.sv
// ---------------------------------------------------------------------------
// tb_dds_sample_feeder
// Directed bench for dds_sample_feeder. A behavioural ROM returns addr*3
// after a programmable number of wait cycles. Expected history words are
// queued from an independent phase model when fetches are launched and are
// popped whenever DDSEnable pulses.
// ---------------------------------------------------------------------------
module tb_dds_sample_feeder;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 12;

    logic        Fg_CLK = 1'b0;
    logic        Fg_RESETn;
    logic [2:0]  DDSMode;
    logic [31:0] TuningWord;
    logic        RunEn;
    logic        ClrUnderrun;
    logic [31:0] out_1;
    logic [31:0] out_2;
    logic        DDSEnable;
    logic        Underrun;

    int          checks   = 0;
    int          failures = 0;

    int          rom_wait  = 0;
    logic        rom_force = 1'b0;
    int          wait_cnt  = 0;
    int          cyc       = 0;

    logic [31:0] sb[$];
    logic [31:0] last_exp    = '0;
    logic [31:0] phase_model = '0;
    int          commits     = 0;
    int          commit_cyc[$];

    dds_sample_feeder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rom_bus ();

    dds_sample_feeder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .Fg_CLK      (Fg_CLK),
        .Fg_RESETn   (Fg_RESETn),
        .DDSMode     (DDSMode),
        .TuningWord  (TuningWord),
        .RunEn       (RunEn),
        .ClrUnderrun (ClrUnderrun),
        .rom         (rom_bus),
        .out_1       (out_1),
        .out_2       (out_2),
        .DDSEnable   (DDSEnable),
        .Underrun    (Underrun)
    );

    always #5 Fg_CLK = ~Fg_CLK;

    // Behavioural ROM: acknowledges after rom_wait cycles of request.
    assign rom_bus.RomAck  = rom_force | (rom_bus.RomReq && (wait_cnt >= rom_wait));
    assign rom_bus.RomData = DATA_W'(32'(rom_bus.RomAddr) * 3);

    always @(posedge Fg_CLK) begin
        cyc <= cyc + 1;
        if (rom_bus.RomReq && !rom_bus.RomAck) wait_cnt <= wait_cnt + 1;
        else                                   wait_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected history word for a phase value: ROM returns addr*3, placed at [29:18].
    function automatic logic [31:0] exp_sample(input logic [31:0] ph);
        int a;
        a = int'(ph >> (32 - ADDR_W));
        return 32'(a * 3) << 18;
    endfunction

    task automatic push_fetch();
        phase_model = phase_model + TuningWord;
        sb.push_back(exp_sample(phase_model));
    endtask

    task automatic clear_model();
        sb.delete();
        commit_cyc.delete();
        last_exp    = '0;
        phase_model = '0;
        commits     = 0;
    endtask

    task automatic do_reset();
        Fg_RESETn   = 1'b0;
        RunEn       = 1'b0;
        DDSMode     = 3'd0;
        TuningWord  = '0;
        ClrUnderrun = 1'b0;
        rom_wait    = 0;
        rom_force   = 1'b0;
        clear_model();
        repeat (2) @(negedge Fg_CLK);
        Fg_RESETn = 1'b1;
        repeat (2) @(negedge Fg_CLK);
    endtask

    // Scoreboard consumer: every DDSEnable pulse pops one expected sample.
    always @(negedge Fg_CLK) begin
        if (Fg_RESETn && DDSEnable) begin
            commits++;
            commit_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_commit observed out_1=%h expected=no commit", out_1);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                check("sb_out_1", out_1, e);
                check("sb_out_2", out_2, last_exp);
                last_exp = e;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset state ----------------
        Fg_RESETn   = 1'b0;
        RunEn       = 1'b0;
        DDSMode     = 3'd0;
        TuningWord  = '0;
        ClrUnderrun = 1'b0;
        #12;
        check("rst_romreq",    32'(rom_bus.RomReq), 32'd0);
        check("rst_romaddr",   32'(rom_bus.RomAddr), 32'd0);
        check("rst_out_1",     out_1, 32'd0);
        check("rst_out_2",     out_2, 32'd0);
        check("rst_ddsenable", 32'(DDSEnable), 32'd0);
        check("rst_underrun",  32'(Underrun), 32'd0);
        do_reset();

        // ---------------- mode 1, zero-wait ROM ----------------
        DDSMode = 3'd1;
        repeat (2) @(negedge Fg_CLK);
        TuningWord = 32'h0040_0000;
        repeat (3) push_fetch();
        RunEn = 1'b1;
        repeat (9) @(negedge Fg_CLK);
        check("m1_no_early_req", 32'(rom_bus.RomReq), 32'd0);
        @(negedge Fg_CLK);
        check("m1_req_1",  32'(rom_bus.RomReq), 32'd1);
        check("m1_addr_1", 32'(rom_bus.RomAddr), 32'd1);
        repeat (10) @(negedge Fg_CLK);
        check("m1_addr_2", 32'(rom_bus.RomAddr), 32'd2);
        repeat (10) @(negedge Fg_CLK);
        check("m1_addr_3", 32'(rom_bus.RomAddr), 32'd3);
        @(negedge Fg_CLK);
        check("m1_out_1",  out_1, 32'h0024_0000);
        check("m1_out_2",  out_2, 32'h0018_0000);
        check("m1_enable", 32'(DDSEnable), 32'd1);
        RunEn = 1'b0;
        repeat (3) @(negedge Fg_CLK);
        check("m1_commits", 32'(commits), 32'd3);
        if (commit_cyc.size() == 3) begin
            check("m1_gap_a", 32'(commit_cyc[1] - commit_cyc[0]), 32'd10);
            check("m1_gap_b", 32'(commit_cyc[2] - commit_cyc[1]), 32'd10);
        end
        check("m1_sb_drained", 32'(sb.size()), 32'd0);

        // ---------------- mode 0, back-to-back ----------------
        do_reset();
        TuningWord = 32'h3333_3334;  // wraps the accumulator within 20 samples
        repeat (20) push_fetch();
        RunEn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Fg_CLK);
            check("m0_req_continuous", 32'(rom_bus.RomReq), 32'd1);
        end
        RunEn = 1'b0;
        @(negedge Fg_CLK);
        #1;
        check("m0_req_idle",    32'(rom_bus.RomReq), 32'd0);
        check("m0_commits",     32'(commits), 32'd20);
        check("m0_underrun",    32'(Underrun), 32'd0);
        check("m0_sb_drained",  32'(sb.size()), 32'd0);

        // ---------------- mode 0, two ROM wait cycles ----------------
        do_reset();
        rom_wait   = 2;
        TuningWord = 32'h0040_0000;
        repeat (2) push_fetch();  // ticks accepted at edges 1 and 4
        RunEn = 1'b1;
        @(negedge Fg_CLK);
        check("ws_req",          32'(rom_bus.RomReq), 32'd1);
        check("ws_underrun_0",   32'(Underrun), 32'd0);
        @(negedge Fg_CLK);
        check("ws_underrun_set", 32'(Underrun), 32'd1);
        ClrUnderrun = 1'b1;
        @(negedge Fg_CLK);
        check("ws_drop_wins",    32'(Underrun), 32'd1);
        @(negedge Fg_CLK);
        check("ws_cleared",      32'(Underrun), 32'd0);
        check("ws_enable",       32'(DDSEnable), 32'd1);
        RunEn       = 1'b0;
        ClrUnderrun = 1'b0;
        repeat (4) @(negedge Fg_CLK);
        #1;
        check("ws_req_idle",     32'(rom_bus.RomReq), 32'd0);
        check("ws_commits",      32'(commits), 32'd2);
        check("ws_sb_drained",   32'(sb.size()), 32'd0);

        // ---------------- mode 1 -> 2 switch mid-period ----------------
        do_reset();
        DDSMode = 3'd1;
        repeat (2) @(negedge Fg_CLK);
        TuningWord = 32'h0040_0000;
        push_fetch();
        RunEn = 1'b1;
        repeat (5) @(negedge Fg_CLK);
        DDSMode = 3'd2;
        repeat (100) @(negedge Fg_CLK);
        check("sw_no_early_req", 32'(rom_bus.RomReq), 32'd0);
        @(negedge Fg_CLK);
        check("sw_req_at_100",   32'(rom_bus.RomReq), 32'd1);
        check("sw_addr",         32'(rom_bus.RomAddr), 32'd1);
        RunEn = 1'b0;
        repeat (3) @(negedge Fg_CLK);
        check("sw_commits",      32'(commits), 32'd1);
        check("sw_sb_drained",   32'(sb.size()), 32'd0);

        // ---------------- RunEn dropped with fetch pending ----------------
        do_reset();
        rom_wait   = 3;
        TuningWord = 32'h0040_0000;
        push_fetch();
        RunEn = 1'b1;
        @(negedge Fg_CLK);
        RunEn = 1'b0;
        check("rd_req_pending",  32'(rom_bus.RomReq), 32'd1);
        repeat (3) @(negedge Fg_CLK);
        check("rd_wait_enable",  32'(DDSEnable), 32'd0);
        check("rd_wait_req",     32'(rom_bus.RomReq), 32'd1);
        @(negedge Fg_CLK);
        check("rd_enable",       32'(DDSEnable), 32'd1);
        check("rd_out_1",        out_1, 32'h000C_0000);
        @(negedge Fg_CLK);
        check("rd_enable_pulse", 32'(DDSEnable), 32'd0);
        repeat (10) @(negedge Fg_CLK);
        check("rd_no_more_req",  32'(rom_bus.RomReq), 32'd0);
        check("rd_commits",      32'(commits), 32'd1);

        // ---------------- reset asserted mid-fetch ----------------
        rom_wait = 3;
        RunEn    = 1'b1;
        push_fetch();
        @(negedge Fg_CLK);
        @(negedge Fg_CLK);
        RunEn = 1'b0;
        check("mr_underrun_pre", 32'(Underrun), 32'd1);
        check("mr_req_pre",      32'(rom_bus.RomReq), 32'd1);
        #2 Fg_RESETn = 1'b0;
        #1;
        check("mr_romreq",    32'(rom_bus.RomReq), 32'd0);
        check("mr_romaddr",   32'(rom_bus.RomAddr), 32'd0);
        check("mr_out_1",     out_1, 32'd0);
        check("mr_out_2",     out_2, 32'd0);
        check("mr_ddsenable", 32'(DDSEnable), 32'd0);
        check("mr_underrun",  32'(Underrun), 32'd0);
        clear_model();
        repeat (2) @(negedge Fg_CLK);
        Fg_RESETn = 1'b1;
        rom_force = 1'b1;  // stray acknowledge with no request outstanding
        for (int i = 0; i < 3; i++) begin
            @(negedge Fg_CLK);
            check("mr_late_ack_enable", 32'(DDSEnable), 32'd0);
        end
        rom_force = 1'b0;
        check("mr_late_ack_out_1", out_1, 32'd0);
        check("mr_commits",        32'(commits), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
